muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide unit and its sequencing controller for the EX stage, sitting beside the ALU.
- Latches operands on a start pulse and runs a fixed-latency busy window, then commits results to the HI/LO architectural registers.
- Also handles MTHI/MTLO writes and exception/interrupt flush.
- Exports a stall request so the hazard unit holds MFHI/MFLO and any further MD ops while the unit is busy.

Parameters:
- MUL_CYCLES, 5, busy-window length for MULT/MULTU (1..15).
- DIV_CYCLES, 10, busy-window length for DIV/DIVU (1..15).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- A  in  32  operand rs (dividend / multiplicand / MTHI-MTLO data)
- B  in  32  operand rt (divisor / multiplier)
- op  in  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7-9 see Optional Feature, others none
- start  in  1  op valid this cycle (EX instruction not stalled)
- flush  in  1  exception/interrupt cancel
- busy  out  1  registered; high during the busy window
- md_stall  out  1  combinational: busy | (start & op is a multi-cycle op & ~flush)
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (asynchronous, any time incl. mid-operation): busy=0, hi=0, lo=0, count=0, state IDLE. Pending result discarded.
- States: IDLE, RUN. A 4-bit down-counter and 64-bit pending result {p_hi,p_lo}.

IDLE, on a rising edge with start=1 & flush=0:
- op 1-4: compute the pending result from A/B sampled this cycle.
  - MULT: signed 32x32->64 → {p_hi,p_lo}.
  - MULTU: unsigned 32x32->64 → {p_hi,p_lo}.
  - DIV: p_lo = signed quotient, truncated toward zero; p_hi = remainder, sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - count loads MUL_CYCLES or DIV_CYCLES. Go to RUN; busy=1 from the next cycle.
- op 5: hi<=A same edge; no busy.
- op 6: lo<=A same edge; no busy.
- op 0 or unused: no effect.

RUN:
- count decrements each edge.
- On the edge where count==1: hi<=p_hi, lo<=p_lo, busy<=0, go to IDLE.
- Net timing: start sampled at edge t; busy high for exactly N cycles; new HI/LO visible the cycle busy falls.
- start in RUN (any op, incl. MTHI/MTLO) is ignored; the hazard unit guarantees stall, and RTL must not corrupt state.
- hi/lo hold their old values throughout RUN.

Flush:
- flush=1 in IDLE blocks any start that cycle (no HI/LO write, no busy).
- flush=1 in RUN aborts: busy<=0, IDLE next edge, HI/LO unchanged, pending discarded.
- flush on the same edge count==1 also aborts: no commit.

Boundary cases:
- Divide by zero (DIV/DIVU, B==0): runs the full DIV_CYCLES window; HI and LO keep their previous values.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no trap.
- MUL_CYCLES=1: busy high exactly one cycle.
- Back-to-back starts: the next op is accepted in the cycle after busy falls.

Optional Feature:
- Macro MULDIV_MADD_EN.
- Defined: ops 7 MADD, 8 MADDU, 9 MSUB enabled, each with MUL_CYCLES latency.
  - Pending value = {hi,lo} ± product (signed for 7/9, unsigned for 8).
  - Uses hi/lo as sampled at start; 64-bit wraparound, no overflow flag.
  - Flush semantics identical to MULT.
- Undefined: ops 7-9 behave as op 0. md_stall does not count them as multi-cycle.

Test Plan:
- Reset mid-DIV (cycle 3 of 10) → busy=0, hi=lo=0 immediately; a later MULT 3*4 gives lo=12, hi=0.
- MULT A=0xFFFFFFFF B=2 → busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV A=-7 (0xFFFFFFF9) B=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 with hi=0x11, lo=0x22 → unchanged after 10 cycles.
- DIV started, flush at busy cycle 10 (commit edge) → busy=0 next cycle, hi/lo unchanged. MTLO 0x5A with flush=1 → lo unchanged.
- MTHI 0xDEADBEEF while busy → ignored; MTHI after busy falls → hi=0xDEADBEEF next cycle. md_stall=1 in the start cycle of MULT, 0 for MTHI.
- MULDIV_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU 1*1 → hi=1, lo=0 after 5 cycles. Without the macro, the same stimulus leaves hi/lo unchanged, busy=0.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: fixed-latency EX-stage multiply/divide unit with HI/LO registers and stall export.
// Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB (ops 7..9); otherwise those opcodes are no-ops.
//
// state  | meaning
// S_IDLE | waiting for an accepted start; MTHI/MTLO write HI/LO directly
// S_RUN  | busy window, counting down to the HI/LO commit edge
module muldiv_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  op,
  input  logic        start,
  input  logic        flush,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MULDIV_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
`endif

  localparam logic [3:0] MUL_LD = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_LD = 4'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q;
  logic [3:0]  count_q;
  logic        busy_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [63:0] pend_q;
  logic        commit_q;

  logic [63:0] pend_d;
  logic        commit_d;
  logic [3:0]  count_ld;
  logic        is_multi;

  logic [63:0] prod_s;
  logic [63:0] prod_u;

  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] div_n;
  logic [31:0] div_d;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // One unsigned divider shared by DIV and DIVU; signed results are rebuilt from magnitudes,
  // which also keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
  assign div_signed = (op == OP_DIV);
  assign a_neg      = div_signed & A[31];
  assign b_neg      = div_signed & B[31];
  assign div_n      = a_neg ? (~A + 32'd1) : A;
  assign div_d      = b_neg ? (~B + 32'd1) : B;
  assign quo        = (div_d == 32'd0) ? 32'd0 : div_n / div_d;
  assign rem        = (div_d == 32'd0) ? 32'd0 : div_n % div_d;
  assign quo_fix    = (a_neg ^ b_neg) ? (~quo + 32'd1) : quo;
  assign rem_fix    = a_neg ? (~rem + 32'd1) : rem;

  always_comb begin
    pend_d   = 64'd0;
    commit_d = 1'b1;
    count_ld = 4'd0;
    is_multi = 1'b0;
    case (op)
      OP_MULT: begin
        is_multi = 1'b1;
        pend_d   = prod_s;
        count_ld = MUL_LD;
      end
      OP_MULTU: begin
        is_multi = 1'b1;
        pend_d   = prod_u;
        count_ld = MUL_LD;
      end
      OP_DIV, OP_DIVU: begin
        is_multi = 1'b1;
        pend_d   = {rem_fix, quo_fix};
        commit_d = (B != 32'd0);
        count_ld = DIV_LD;
      end
`ifdef MULDIV_MADD_EN
      OP_MADD: begin
        is_multi = 1'b1;
        pend_d   = {hi_q, lo_q} + prod_s;
        count_ld = MUL_LD;
      end
      OP_MADDU: begin
        is_multi = 1'b1;
        pend_d   = {hi_q, lo_q} + prod_u;
        count_ld = MUL_LD;
      end
      OP_MSUB: begin
        is_multi = 1'b1;
        pend_d   = {hi_q, lo_q} - prod_s;
        count_ld = MUL_LD;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= 4'd0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      pend_q   <= 64'd0;
      commit_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            if (is_multi) begin
              pend_q   <= pend_d;
              commit_q <= commit_d;
              count_q  <= count_ld;
              busy_q   <= 1'b1;
              state_q  <= S_RUN;
            end else if (op == OP_MTHI) begin
              hi_q <= A;
            end else if (op == OP_MTLO) begin
              lo_q <= A;
            end
          end
        end
        S_RUN: begin
          // Any start seen here is ignored; the hazard unit is already stalling the pipe.
          count_q <= count_q - 4'd1;
          if (flush) begin
            count_q <= 4'd0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (count_q == 4'd1) begin
            if (commit_q) begin
              hi_q <= pend_q[63:32];
              lo_q <= pend_q[31:0];
            end
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign md_stall = busy_q | (start & is_multi & ~flush);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: fixed vectors, hand-written flush/reset/intrusion sequences, and
// randomized ops checked against an arithmetic reference model.
module tb_muldiv_ctrl;

  localparam int MULC = 5;
  localparam int DIVC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [3:0]  op = 4'd0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        busy, md_stall;
  logic [31:0] hi, lo;
  logic        busy_s, md_stall_s;
  logic [31:0] hi_s, lo_s;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t tbl[12];

  muldiv_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .start(start), .flush(flush),
    .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
  );

  muldiv_ctrl #(.MUL_CYCLES(1), .DIV_CYCLES(1)) dut_s (
    .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .start(start), .flush(flush),
    .busy(busy_s), .md_stall(md_stall_s), .hi(hi_s), .lo(lo_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result of one accepted op, from plain integer arithmetic.
  function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] h, input logic [31:0] l,
                                output int n, output logic [31:0] eh, output logic [31:0] el);
    int          sa, sb;
    longint      ps, q, r;
    logic [63:0] pu, acc;
    sa  = a;
    sb  = b;
    ps  = longint'(sa) * longint'(sb);
    pu  = {32'd0, a} * {32'd0, b};
    acc = {h, l};
    n   = 0;
    eh  = h;
    el  = l;
    case (o)
      4'd1: begin n = MULC; {eh, el} = ps; end
      4'd2: begin n = MULC; {eh, el} = pu; end
      4'd3: begin
        n = DIVC;
        if (b != 32'd0) begin
          q  = longint'(sa) / longint'(sb);
          r  = longint'(sa) % longint'(sb);
          el = 32'(q);
          eh = 32'(r);
        end
      end
      4'd4: begin
        n = DIVC;
        if (b != 32'd0) begin el = a / b; eh = a % b; end
      end
      4'd5: eh = a;
      4'd6: el = a;
`ifdef MULDIV_MADD_EN
      4'd7: begin n = MULC; {eh, el} = acc + 64'(ps); end
      4'd8: begin n = MULC; {eh, el} = acc + pu; end
      4'd9: begin n = MULC; {eh, el} = acc - 64'(ps); end
`endif
      default: ;
    endcase
  endfunction

  // Called at a negedge with the unit idle. fl_at: -1 none, 0 flush with start, k flush at busy cycle k.
  // inj: issue MTHI 0xDEADBEEF during busy cycle 1.
  task automatic exec(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                      input int n, input logic [31:0] eh, input logic [31:0] el,
                      input int fl_at, input bit inj);
    bit aborted;
    int ne;
    aborted = 1'b0;
    ne = (fl_at == 0) ? 0 : n;
    op = o; A = a; B = b; start = 1'b1; flush = (fl_at == 0);
    #1 chk("md_stall_start", 32'(md_stall), 32'(ne > 0));
    @(negedge clk);
    start = 1'b0; op = 4'd0; flush = 1'b0;
    for (int i = 1; i <= ne; i++) begin
      chk("busy_high", 32'(busy), 32'd1);
      chk("stall_busy", 32'(md_stall), 32'd1);
      chk("hi_hold", hi, cur_hi);
      chk("lo_hold", lo, cur_lo);
      if (i == fl_at) flush = 1'b1;
      if (inj && i == 1) begin op = 4'd5; A = 32'hDEADBEEF; start = 1'b1; end
      @(negedge clk);
      flush = 1'b0; start = 1'b0; op = 4'd0;
      if (i == fl_at) begin aborted = 1'b1; break; end
    end
    chk("busy_done", 32'(busy), 32'd0);
    if (!aborted && fl_at != 0) begin cur_hi = eh; cur_lo = el; end
    chk("hi", hi, cur_hi);
    chk("lo", lo, cur_lo);
  endtask

  task automatic run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                     input int fl_at, input bit inj);
    int n;
    logic [31:0] eh, el;
    model(o, a, b, cur_hi, cur_lo, n, eh, el);
    exec(o, a, b, n, eh, el, fl_at, inj);
  endtask

  initial begin
    tbl[0]  = '{4'd1,  32'hFFFFFFFF, 32'd2,        MULC, 32'hFFFFFFFF, 32'hFFFFFFFE};
    tbl[1]  = '{4'd2,  32'hFFFFFFFF, 32'd2,        MULC, 32'h00000001, 32'hFFFFFFFE};
    tbl[2]  = '{4'd3,  32'hFFFFFFF9, 32'd2,        DIVC, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3]  = '{4'd5,  32'h00000011, 32'd0,        0,    32'h00000011, 32'hFFFFFFFD};
    tbl[4]  = '{4'd6,  32'h00000022, 32'd0,        0,    32'h00000011, 32'h00000022};
    tbl[5]  = '{4'd4,  32'd7,        32'd0,        DIVC, 32'h00000011, 32'h00000022};
    tbl[6]  = '{4'd3,  32'h80000000, 32'hFFFFFFFF, DIVC, 32'h00000000, 32'h80000000};
    tbl[7]  = '{4'd4,  32'd100,      32'd7,        DIVC, 32'd2,        32'd14};
    tbl[8]  = '{4'd1,  32'd7,        32'hFFFFFFFD, MULC, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tbl[9]  = '{4'd3,  32'd7,        32'hFFFFFFFE, DIVC, 32'h00000001, 32'hFFFFFFFD};
    tbl[10] = '{4'd0,  32'h12345678, 32'd9,        0,    32'h00000001, 32'hFFFFFFFD};
    tbl[11] = '{4'd15, 32'h12345678, 32'd9,        0,    32'h00000001, 32'hFFFFFFFD};

    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset in busy cycle 3 of a DIV wipes HI/LO and the pending result.
    run(4'd5, 32'h11, 32'd0, -1, 1'b0);
    run(4'd6, 32'h22, 32'd0, -1, 1'b0);
    op = 4'd3; A = 32'd100; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    repeat (2) @(negedge clk);
    chk("div_busy_c3", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_hi", hi, 32'd0);
    chk("async_rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cur_hi = 32'd0; cur_lo = 32'd0;

    // MULT 3*4 on both instances; the MUL_CYCLES=1 instance is busy for exactly one cycle.
    op = 4'd1; A = 32'd3; B = 32'd4; start = 1'b1;
    #1 chk("mult_stall", 32'(md_stall), 32'd1);
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    chk("short_busy_c1", 32'(busy_s), 32'd1);
    chk("busy_c1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("short_busy_c2", 32'(busy_s), 32'd0);
    chk("short_lo", lo_s, 32'd12);
    chk("short_hi", hi_s, 32'd0);
    repeat (3) @(negedge clk);
    chk("busy_c5", 32'(busy), 32'd1);
    chk("lo_hold_c5", lo, 32'd0);
    @(negedge clk);
    chk("busy_c6", 32'(busy), 32'd0);
    chk("mult_lo", lo, 32'd12);
    chk("mult_hi", hi, 32'd0);
    cur_lo = 32'd12;

    foreach (tbl[k])
      exec(tbl[k].op, tbl[k].a, tbl[k].b, tbl[k].cyc, tbl[k].ehi, tbl[k].elo, -1, 1'b0);

    // Flush on the commit edge, mid-run flush, and start blocked by flush.
    exec(4'd3, 32'd100, 32'd7, DIVC, 32'd2, 32'd14, DIVC, 1'b0);
    exec(4'd1, 32'd9, 32'd9, MULC, 32'd0, 32'd81, 4, 1'b0);
    exec(4'd6, 32'h5A, 32'd0, 0, cur_hi, 32'h5A, 0, 1'b0);
    exec(4'd1, 32'd1, 32'd1, MULC, 32'd0, 32'd1, 0, 1'b0);

    // MTHI during busy is ignored; MTHI right after busy falls lands.
    exec(4'd1, 32'd3, 32'd5, MULC, 32'd0, 32'd15, -1, 1'b1);
    exec(4'd5, 32'hDEADBEEF, 32'd0, 0, 32'hDEADBEEF, 32'd15, -1, 1'b0);

    run(4'd5, 32'd0, 32'd0, -1, 1'b0);
    run(4'd6, 32'hFFFFFFFF, 32'd0, -1, 1'b0);
`ifdef MULDIV_MADD_EN
    exec(4'd8, 32'd1, 32'd1, MULC, 32'd1, 32'd0, -1, 1'b0);
`else
    exec(4'd8, 32'd1, 32'd1, 0, 32'd0, 32'hFFFFFFFF, -1, 1'b0);
`endif

    for (int k = 0; k < 80; k++) begin
      logic [3:0]  o;
      logic [31:0] a, b, eh, el;
      int          n, fa;
      o = 4'($urandom_range(0, 10));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 3));
        1: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      model(o, a, b, cur_hi, cur_lo, n, eh, el);
      fa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 32'(n))) : -1;
      exec(o, a, b, n, eh, el, fa, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
